// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the pipeline control logic.
//   WAIT_LIMIT_DEFAULT : default wait-state budget per memory/IO access
//   WAIT_CNT_W         : width of the wait-state counter
//   main_state_e       : main stall FSM encoding (run / memory wait / timeout)
//   refill_state_e     : program cache refill FSM encoding (idle / fill)
package cpu_pkg;

    localparam int unsigned WAIT_CNT_W         = 8;
    localparam logic [7:0]  WAIT_LIMIT_DEFAULT = 8'd255;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StTimeout = 2'd2
    } main_state_e;

    typedef enum logic {
        StIdle = 1'b0,
        StFill = 1'b1
    } refill_state_e;

endpackage

// File: rtl/wait_timer.sv
// Wait-state counter for memory/IO accesses.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset (already release-synchronised)
//   load    : restart the count at zero
//   enable  : count one wait cycle (holds once the limit is reached)
//   limit   : wait-state budget
//   expired : count has reached limit
module wait_timer
    import cpu_pkg::*;
#(
    parameter int unsigned W = WAIT_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= '0;
        end else if (enable && (count_q != limit)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign expired = (count_q == limit);

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline stall / flush controller.
//   clk, rst_n               : clock and asynchronous active-low reset
//   pc_jmp, pc_call, pc_ret  : decode-stage control-transfer strobes
//   pc_brx, brx_taken        : execute-stage conditional branch and its outcome
//   mem_req, mem_ready       : execute-stage memory/IO access and its acknowledge
//   p_cache_miss/_ready      : program cache miss and refill-complete
//   stall_clr                : clears stall_count and bus_error
//   hazard                   : freeze decode/execute
//   input_flush/output_flush : NOP the fetched instruction / cancel decoded controls
//   jmp_rst, brx_rst         : clear the decode jump/call and branch strobes
//   refill_req               : program cache line fill request
//   bus_error                : sticky wait-state timeout flag
//   stall_count              : saturating count of hazard cycles
// All outputs are registered.
module pipeline_controller
    import cpu_pkg::*;
#(
    parameter logic [7:0]  WAIT_LIMIT  = WAIT_LIMIT_DEFAULT,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pc_jmp,
    input  logic                   pc_call,
    input  logic                   pc_ret,
    input  logic                   pc_brx,
    input  logic                   brx_taken,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    input  logic                   p_cache_miss,
    input  logic                   p_cache_ready,
    input  logic                   stall_clr,
    output logic                   hazard,
    output logic                   input_flush,
    output logic                   output_flush,
    output logic                   jmp_rst,
    output logic                   brx_rst,
    output logic                   refill_req,
    output logic                   bus_error,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // Reset asserts asynchronously, releases two clocks after rst_n rises.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    main_state_e             state_q;
    refill_state_e           refill_q;
    logic                    hazard_q, bus_error_q, refill_req_q;
    logic                    input_flush_q, output_flush_q, jmp_rst_q, brx_rst_q;
    logic                    pend_jmp_q, pend_ret_q, pend_brx_q, pend_taken_q;
    logic [STALL_CNT_W-1:0]  stall_count_q;

    logic stall_start, timeout_hit, timer_expired, flush_ok;
    logic req_jmp, req_ret, req_brx, req_taken;

    always_comb begin
        stall_start = (state_q == StRun) && mem_req && !mem_ready;
        timeout_hit = (state_q == StMemWait) && !mem_ready && timer_expired;
        // A stall starting this cycle wins over any flush; strobes wait in pending.
        flush_ok    = !hazard_q && !stall_start;
        req_jmp     = pend_jmp_q | pc_jmp | pc_call;
        req_ret     = pend_ret_q | pc_ret;
        req_brx     = pend_brx_q | pc_brx;
        req_taken   = pend_taken_q | (pc_brx & brx_taken);
    end

    wait_timer #(
        .W (WAIT_CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_int_n),
        .load    (stall_start),
        .enable  (state_q == StMemWait),
        .limit   (WAIT_LIMIT),
        .expired (timer_expired)
    );

    // Main stall FSM
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= StRun;
            hazard_q    <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (stall_start) begin
                        state_q  <= StMemWait;
                        hazard_q <= 1'b1;
                    end
                end
                StMemWait: begin
                    if (mem_ready) begin
                        state_q  <= StRun;
                        hazard_q <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q  <= StTimeout;
                        hazard_q <= 1'b0;
                    end
                end
                StTimeout: begin
                    // Single cycle; a late mem_ready is dropped.
                    state_q <= StRun;
                end
                default: begin
                    state_q  <= StRun;
                    hazard_q <= 1'b0;
                end
            endcase
            // Timeout beats a simultaneous clear.
            if (timeout_hit) begin
                bus_error_q <= 1'b1;
            end else if (stall_clr) begin
                bus_error_q <= 1'b0;
            end
        end
    end

    // Flush pulses; coincident requests merge into one pulse of the union.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            input_flush_q  <= 1'b0;
            output_flush_q <= 1'b0;
            jmp_rst_q      <= 1'b0;
            brx_rst_q      <= 1'b0;
            pend_jmp_q     <= 1'b0;
            pend_ret_q     <= 1'b0;
            pend_brx_q     <= 1'b0;
            pend_taken_q   <= 1'b0;
        end else if (flush_ok) begin
            input_flush_q  <= req_jmp | req_ret | req_taken;
            output_flush_q <= req_taken;
            jmp_rst_q      <= req_jmp;
            brx_rst_q      <= req_brx;
            pend_jmp_q     <= 1'b0;
            pend_ret_q     <= 1'b0;
            pend_brx_q     <= 1'b0;
            pend_taken_q   <= 1'b0;
        end else begin
            input_flush_q  <= 1'b0;
            output_flush_q <= 1'b0;
            jmp_rst_q      <= 1'b0;
            brx_rst_q      <= 1'b0;
            pend_jmp_q     <= req_jmp;
            pend_ret_q     <= req_ret;
            pend_brx_q     <= req_brx;
            pend_taken_q   <= req_taken;
        end
    end

    // Saturating stall performance counter
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            stall_count_q <= '0;
        end else if (stall_clr) begin
            stall_count_q <= '0;
        end else if (hazard_q && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + STALL_CNT_W'(1);
        end
    end

    // Program cache refill FSM; never stalls the pipeline, decode inserts its own NOPs.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            refill_q     <= StIdle;
            refill_req_q <= 1'b0;
        end else begin
            unique case (refill_q)
                StIdle: begin
                    if (p_cache_miss) begin
                        refill_q     <= StFill;
                        refill_req_q <= 1'b1;
                    end
                end
                StFill: begin
                    if (p_cache_ready) begin
                        refill_q     <= StIdle;
                        refill_req_q <= 1'b0;
                    end
                end
                default: begin
                    refill_q     <= StIdle;
                    refill_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign hazard       = hazard_q;
    assign input_flush  = input_flush_q;
    assign output_flush = output_flush_q;
    assign jmp_rst      = jmp_rst_q;
    assign brx_rst      = brx_rst_q;
    assign refill_req   = refill_req_q;
    assign bus_error    = bus_error_q;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller (WAIT_LIMIT=4, 4-bit stall counter).
module tb_pipeline_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pc_jmp, pc_call, pc_ret, pc_brx, brx_taken;
    logic       mem_req, mem_ready, p_cache_miss, p_cache_ready, stall_clr;
    logic       hazard, input_flush, output_flush, jmp_rst, brx_rst, refill_req, bus_error;
    logic [3:0] stall_count;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    pipeline_controller #(
        .WAIT_LIMIT  (8'd4),
        .STALL_CNT_W (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_jmp        (pc_jmp),
        .pc_call       (pc_call),
        .pc_ret        (pc_ret),
        .pc_brx        (pc_brx),
        .brx_taken     (brx_taken),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .p_cache_miss  (p_cache_miss),
        .p_cache_ready (p_cache_ready),
        .stall_clr     (stall_clr),
        .hazard        (hazard),
        .input_flush   (input_flush),
        .output_flush  (output_flush),
        .jmp_rst       (jmp_rst),
        .brx_rst       (brx_rst),
        .refill_req    (refill_req),
        .bus_error     (bus_error),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {input_flush, output_flush, jmp_rst, brx_rst}
    function automatic logic [3:0] pulses();
        return {input_flush, output_flush, jmp_rst, brx_rst};
    endfunction

    // Access acknowledged on the ready_after-th edge after the request edge.
    task automatic mem_stall(input int unsigned ready_after);
        mem_req = 1'b1; mem_ready = 1'b0;
        step();
        mem_req = 1'b0;
        repeat (ready_after - 1) step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
    endtask

    task automatic timeout_run();
        mem_req = 1'b1; mem_ready = 1'b0;
        step();
        mem_req = 1'b0;
        repeat (8) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        int unsigned hc;
        int unsigned rc;
        logic        hz_seen;

        {pc_jmp, pc_call, pc_ret, pc_brx, brx_taken} = '0;
        {mem_req, mem_ready, p_cache_miss, p_cache_ready, stall_clr} = '0;
        rst_n = 1'b0;
        repeat (2) step();
        check_eq("reset_outputs",
                 {hazard, input_flush, output_flush, jmp_rst, brx_rst, refill_req, bus_error},
                 7'd0);
        check_eq("reset_stall_count", stall_count, 4'd0);
        rst_n = 1'b1;
        repeat (4) step();

        // Three wait states
        hc = 0;
        mem_req = 1'b1; mem_ready = 1'b0;
        step();
        check_eq("stall_hazard_rise", hazard, 1'b1);
        hc += hazard;
        mem_req = 1'b0;
        repeat (2) begin step(); hc += hazard; end
        mem_ready = 1'b1;
        step(); hc += hazard;
        mem_ready = 1'b0;
        repeat (3) begin step(); hc += hazard; end
        check_eq("stall3_hazard_cycles", hc, 3);
        check_eq("stall3_count", stall_count, 4'd3);
        check_eq("stall3_bus_error", bus_error, 1'b0);

        // Zero wait states
        mem_req = 1'b1; mem_ready = 1'b1;
        step();
        check_eq("zero_wait_no_hazard", hazard, 1'b0);
        mem_req = 1'b0; mem_ready = 1'b0;
        step();

        stall_clr = 1'b1; step(); stall_clr = 1'b0;
        check_eq("clr_count", stall_count, 4'd0);

        // Timeout with WAIT_LIMIT=4
        hc = 0;
        mem_req = 1'b1; mem_ready = 1'b0;
        step(); hc += hazard;
        mem_req = 1'b0;
        repeat (9) begin step(); hc += hazard; end
        check_eq("timeout_hazard_cycles", hc, 5);
        check_eq("timeout_bus_error", bus_error, 1'b1);
        check_eq("timeout_hazard_released", hazard, 1'b0);
        check_eq("timeout_count", stall_count, 4'd5);

        stall_clr = 1'b1; step(); stall_clr = 1'b0;
        check_eq("clr_bus_error", bus_error, 1'b0);
        check_eq("clr_count2", stall_count, 4'd0);

        // Timeout coincides with stall_clr
        mem_req = 1'b1; mem_ready = 1'b0;
        step();
        mem_req = 1'b0;
        repeat (4) step();
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        check_eq("timeout_beats_clr", bus_error, 1'b1);
        check_eq("clr_with_hazard_count", stall_count, 4'd0);
        repeat (2) step();

        // Branches
        pc_brx = 1'b1; brx_taken = 1'b1;
        step();
        pc_brx = 1'b0; brx_taken = 1'b0;
        check_eq("brx_taken_pulse", pulses(), 4'b1101);
        step();
        check_eq("brx_taken_end", pulses(), 4'b0000);
        pc_brx = 1'b1; brx_taken = 1'b0;
        step();
        pc_brx = 1'b0;
        check_eq("brx_not_taken_pulse", pulses(), 4'b0001);
        step();

        // Jump and return
        pc_jmp = 1'b1; step(); pc_jmp = 1'b0;
        check_eq("jmp_pulse", pulses(), 4'b1010);
        step();
        check_eq("jmp_end", pulses(), 4'b0000);
        pc_ret = 1'b1; step(); pc_ret = 1'b0;
        check_eq("ret_pulse", pulses(), 4'b1000);
        step();

        // Jump and taken branch together merge
        pc_jmp = 1'b1; pc_brx = 1'b1; brx_taken = 1'b1;
        step();
        pc_jmp = 1'b0; pc_brx = 1'b0; brx_taken = 1'b0;
        check_eq("union_pulse", pulses(), 4'b1111);
        step();
        check_eq("union_single", pulses(), 4'b0000);

        // Stall start has priority over a simultaneous jump
        pc_jmp = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        step();
        pc_jmp = 1'b0; mem_req = 1'b0;
        check_eq("prio_hazard", hazard, 1'b1);
        check_eq("prio_no_flush", pulses(), 4'b0000);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check_eq("prio_still_pending", pulses(), 4'b0000);
        step();
        check_eq("prio_released", pulses(), 4'b1010);
        step();
        check_eq("prio_once", pulses(), 4'b0000);

        // Call during a 2-cycle stall
        mem_req = 1'b1; mem_ready = 1'b0;
        step();
        mem_req = 1'b0; pc_call = 1'b1;
        step();
        pc_call = 1'b0;
        check_eq("call_held", pulses(), 4'b0000);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check_eq("call_hazard_drop", hazard, 1'b0);
        check_eq("call_not_yet", pulses(), 4'b0000);
        step();
        check_eq("call_pulse", pulses(), 4'b1010);
        step();
        check_eq("call_once", pulses(), 4'b0000);

        // Refill: ready arrives 6 cycles after the miss
        rc = 0; hz_seen = 1'b0;
        p_cache_miss = 1'b1;
        step();
        p_cache_miss = 1'b0;
        rc += refill_req; hz_seen |= hazard;
        for (int i = 0; i < 5; i++) begin
            p_cache_miss = (i == 2);
            step();
            rc += refill_req; hz_seen |= hazard;
        end
        p_cache_miss = 1'b0;
        p_cache_ready = 1'b1;
        step();
        p_cache_ready = 1'b0;
        rc += refill_req; hz_seen |= hazard;
        check_eq("refill_cycles", rc, 6);
        check_eq("refill_no_hazard", hz_seen, 1'b0);
        step();
        check_eq("refill_idle", refill_req, 1'b0);

        // Reset mid-fill
        p_cache_miss = 1'b1; step(); p_cache_miss = 1'b0;
        step();
        check_eq("fill_active", refill_req, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_eq("reset_mid_fill", refill_req, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (4) step();
        check_eq("after_reset_idle", refill_req, 1'b0);

        // Saturation: 5 + 5 + 3 = 13, then +3 saturates at 15
        timeout_run();
        timeout_run();
        mem_stall(3);
        check_eq("count_13", stall_count, 4'd13);
        mem_stall(3);
        check_eq("count_saturated", stall_count, 4'd15);
        stall_clr = 1'b1; step(); stall_clr = 1'b0;
        check_eq("sat_clr_count", stall_count, 4'd0);
        check_eq("sat_clr_bus_error", bus_error, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 8'd255, giving the maximum wait-state cycles per memory/IO access before timeout.
REQ-002 SHALL have parameter STALL_CNT_W, default 16, giving the width of the stall performance counter.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; all outputs SHALL be registered.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 pc_jmp, pc_call, pc_ret  in  1 each  decode-stage control-transfer strobes.
REQ-007 pc_brx  in  1  conditional branch in execute.
REQ-008 brx_taken  in  1  branch condition result; valid only when pc_brx=1.
REQ-009 mem_req  in  1  execute-stage access pending: OR of data_ren, data_wren, IO_ren and IO_wren.
REQ-010 mem_ready  in  1  external memory/IO acknowledge.
REQ-011 p_cache_miss  in  1  program cache miss.
REQ-012 p_cache_ready  in  1  program cache refill complete.
REQ-013 stall_clr  in  1  synchronous clear of stall_count and bus_error.
REQ-014 hazard  out  1  freeze decode/execute.
REQ-015 input_flush  out  1  replace the fetched instruction with NOP.
REQ-016 output_flush  out  1  cancel the decoded controls.
REQ-017 jmp_rst  out  1  clear pc_jmp/pc_call.
REQ-018 brx_rst  out  1  clear pc_brx.
REQ-019 refill_req  out  1  request a program cache line fill.
REQ-020 bus_error  out  1  sticky flag set on wait timeout.
REQ-021 stall_count  out  STALL_CNT_W  saturating count of hazard cycles.

Function
REQ-022 Main FSM states SHALL be RUN, MEM_WAIT and TIMEOUT; the refill FSM states SHALL be IDLE and FILL, and the refill FSM SHALL run independently of the main FSM.
REQ-023 RUN with mem_req=1 and mem_ready=0 SHALL go to MEM_WAIT, assert hazard from the next cycle, and load wait_cnt=0.
REQ-024 MEM_WAIT SHALL increment wait_cnt each cycle; mem_ready=1 SHALL return the FSM to RUN and deassert hazard on the next cycle.
REQ-025 MEM_WAIT with wait_cnt==WAIT_LIMIT and mem_ready=0 SHALL go to TIMEOUT, set bus_error, and deassert hazard one cycle later.
REQ-026 TIMEOUT SHALL last exactly one cycle and then return to RUN; mem_ready seen during TIMEOUT SHALL be ignored.
REQ-027 mem_req with mem_ready=1 in RUN SHALL cause no stall (zero wait states).
REQ-028 In RUN with hazard=0, pc_jmp, pc_call or pc_ret SHALL assert input_flush for exactly 1 cycle, beginning the cycle after the strobe.
REQ-029 pc_jmp or pc_call SHALL additionally pulse jmp_rst for 1 cycle in that same cycle.
REQ-030 pc_brx SHALL pulse brx_rst for 1 cycle the cycle after the strobe, in every case.
REQ-031 If brx_taken=1, input_flush and output_flush SHALL also each pulse for 1 cycle, in the same cycle as brx_rst.
REQ-032 Control strobes arriving while hazard=1 SHALL be held pending and acted on the first cycle hazard=0; a memory stall SHALL take priority over a flush.
REQ-033 Simultaneous jump and taken branch SHALL produce single pulses of the union of the outputs, not two pulses each.
REQ-034 In refill IDLE, p_cache_miss=1 SHALL go to FILL and set refill_req on the next cycle.
REQ-035 In FILL, refill_req SHALL stay high until p_cache_ready=1, then drop on the following cycle and return to IDLE.
REQ-036 p_cache_miss seen during FILL SHALL be ignored.
REQ-037 The refill FSM SHALL NOT assert hazard, because decode inserts its own NOPs on a miss.
REQ-038 stall_count SHALL increment on every cycle with hazard=1 and saturate at all-ones without wrapping.
REQ-039 stall_clr SHALL zero stall_count and bus_error; if stall_clr and a timeout occur together, the timeout SHALL win and set bus_error.

Reset
REQ-040 rst_n=0 SHALL asynchronously force both FSMs to RUN/IDLE and drive hazard, input_flush, output_flush, jmp_rst, brx_rst, refill_req and bus_error to 0, stall_count to 0, wait_cnt to 0, and clear all pending strobes.
REQ-041 Reset during MEM_WAIT or FILL SHALL abandon the transaction with no further output pulses.
REQ-042 Deassertion of rst_n SHALL be synchronised (assert async, release sync) inside the block.

Structure
REQ-043 FSM state encodings and the default WAIT_LIMIT SHALL reside in the shared package cpu_pkg.
REQ-044 The wait/timeout counter SHALL be the sub-module wait_timer (load, enable, limit compare, expired output); all other logic SHALL be flat.

Verification
REQ-045 mem_req=1, mem_ready low for 3 cycles -> hazard high exactly 3 cycles, stall_count=3, bus_error=0.
REQ-046 WAIT_LIMIT=4, mem_ready held 0 -> TIMEOUT after 5 wait cycles, bus_error=1, hazard released, stall_count=5.
REQ-047 pc_brx=1 with brx_taken=1 -> next cycle brx_rst=input_flush=output_flush=1 for one cycle; with brx_taken=0 -> brx_rst only.
REQ-048 pc_call during a 2-cycle memory stall -> input_flush and jmp_rst pulse on the first cycle after hazard drops, once.
REQ-049 p_cache_miss pulse, p_cache_ready after 6 cycles -> refill_req high 6 cycles, hazard stays 0; rst_n low mid-fill -> refill_req 0 immediately.
REQ-050 stall_count preloaded near all-ones and 3 hazard cycles -> counter holds all-ones; stall_clr -> 0.
